// File: rtl/cnn_bn_param_feeder_if.sv
// Pixel, parameter-load and parameter-stream signals between the upstream source and the BN feeder.
// The master modport is the source/sink side; the slave modport is the feeder itself.
interface cnn_bn_param_feeder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  param_clr;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_weight;
  logic [DATA_WIDTH-1:0] load_bias;
  logic                  load_done;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_weight_out;
  logic [DATA_WIDTH-1:0] weight_out;
  logic                  valid_bias_out;
  logic [DATA_WIDTH-1:0] bias_out;
  logic                  frame_done;
  logic                  err;

  modport master (
    output param_clr, load_valid, load_weight, load_bias, valid_in, pxl_in,
    input  load_done, valid_out, pxl_out, valid_weight_out, weight_out,
           valid_bias_out, bias_out, frame_done, err
  );

  modport slave (
    input  param_clr, load_valid, load_weight, load_bias, valid_in, pxl_in,
    output load_done, valid_out, pxl_out, valid_weight_out, weight_out,
           valid_bias_out, bias_out, frame_done, err
  );
endinterface

// File: rtl/cnn_bn_param_feeder.sv
// Per-channel FP32 weight/bias sequencer feeding the BN stage alongside a channel-major pixel stream.
// One-cycle latency, one pixel per cycle, no backpressure: output valid mirrors valid_in gaps exactly.
module cnn_bn_param_feeder #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_CHANNEL     = 64,
  parameter int PXL_PER_CHANNEL = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  cnn_bn_param_feeder_if.slave    bus
);
  localparam int CW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam int PW = (PXL_PER_CHANNEL > 1) ? $clog2(PXL_PER_CHANNEL) : 1;
  localparam logic [CW-1:0] CH_LAST = CW'(NUM_CHANNEL - 1);
  localparam logic [PW-1:0] PX_LAST = PW'(PXL_PER_CHANNEL - 1);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]         ch_cnt_q, ch_cnt_d;
  logic [PW-1:0]         px_cnt_q, px_cnt_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] pxl_q, pxl_d;
  logic [DATA_WIDTH-1:0] weight_q, weight_d;
  logic [DATA_WIDTH-1:0] bias_q, bias_d;
  logic                  wr_en;

  // Parameter storage survives reset; a reload is always required after reset anyway.
  logic [DATA_WIDTH-1:0] weight_mem_q [NUM_CHANNEL];
  logic [DATA_WIDTH-1:0] bias_mem_q   [NUM_CHANNEL];

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    px_cnt_d     = px_cnt_q;
    err_d        = err_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    pxl_d        = pxl_q;
    weight_d     = weight_q;
    bias_d       = bias_q;
    wr_en        = 1'b0;

    if (bus.param_clr) begin
      state_d  = ST_LOAD;
      ld_cnt_d = '0;
      ch_cnt_d = '0;
      px_cnt_d = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.valid_in) err_d = 1'b1;
          if (bus.load_valid) begin
            wr_en = 1'b1;
            if (ld_cnt_q == CH_LAST) begin
              ld_cnt_d = '0;
              state_d  = ST_RUN;
            end else begin
              ld_cnt_d = ld_cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.load_valid) err_d = 1'b1;
          if (bus.valid_in) begin
            valid_d  = 1'b1;
            pxl_d    = bus.pxl_in;
            weight_d = weight_mem_q[ch_cnt_q];
            bias_d   = bias_mem_q[ch_cnt_q];
            if (px_cnt_q == PX_LAST) begin
              px_cnt_d = '0;
              if (ch_cnt_q == CH_LAST) begin
                ch_cnt_d     = '0;
                frame_done_d = 1'b1;
              end else begin
                ch_cnt_d = ch_cnt_q + 1'b1;
              end
            end else begin
              px_cnt_d = px_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      ld_cnt_q     <= '0;
      ch_cnt_q     <= '0;
      px_cnt_q     <= '0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pxl_q        <= '0;
      weight_q     <= '0;
      bias_q       <= '0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      px_cnt_q     <= px_cnt_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      pxl_q        <= pxl_d;
      weight_q     <= weight_d;
      bias_q       <= bias_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      weight_mem_q[ld_cnt_q] <= bus.load_weight;
      bias_mem_q[ld_cnt_q]   <= bus.load_bias;
    end
  end

  assign bus.load_done        = (state_q == ST_RUN);
  assign bus.valid_out        = valid_q;
  assign bus.valid_weight_out = valid_q;
  assign bus.valid_bias_out   = valid_q;
  assign bus.pxl_out          = pxl_q;
  assign bus.weight_out       = weight_q;
  assign bus.bias_out         = bias_q;
  assign bus.frame_done       = frame_done_q;
  assign bus.err              = err_q;
endmodule

// File: tb/tb_cnn_bn_param_feeder.sv
// Directed plus randomized bench for cnn_bn_param_feeder against a frame-index reference model.
module tb_cnn_bn_param_feeder;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int PPC = 3;
  localparam int FR  = NCH * PPC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cnn_bn_param_feeder_if #(.DATA_WIDTH(DW)) bus ();

  cnn_bn_param_feeder #(
    .DATA_WIDTH(DW), .NUM_CHANNEL(NCH), .PXL_PER_CHANNEL(PPC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int fd_count;

  // Reference model: a loaded flag, a load index and a single pixel index within the frame.
  logic [31:0] m_w [NCH];
  logic [31:0] m_b [NCH];
  bit          m_loaded;
  int          m_ld;
  int          m_pix;
  bit          m_err, m_vout, m_fd;
  logic [31:0] m_pxl, m_wo, m_bo;
  string       phase;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_loaded = 0; m_ld = 0; m_pix = 0; m_err = 0;
    m_vout = 0; m_fd = 0; m_pxl = '0; m_wo = '0; m_bo = '0;
  endtask

  task automatic check_all();
    chk("valid_out", {31'd0, bus.valid_out}, {31'd0, m_vout});
    chk("valid_weight_out", {31'd0, bus.valid_weight_out}, {31'd0, m_vout});
    chk("valid_bias_out", {31'd0, bus.valid_bias_out}, {31'd0, m_vout});
    chk("pxl_out", bus.pxl_out, m_pxl);
    chk("weight_out", bus.weight_out, m_wo);
    chk("bias_out", bus.bias_out, m_bo);
    chk("frame_done", {31'd0, bus.frame_done}, {31'd0, m_fd});
    chk("load_done", {31'd0, bus.load_done}, {31'd0, m_loaded});
    chk("err", {31'd0, bus.err}, {31'd0, m_err});
  endtask

  task automatic cyc(input bit clr, input bit lv, input logic [31:0] lw, input logic [31:0] lb,
                     input bit vi, input logic [31:0] px);
    bus.param_clr = clr; bus.load_valid = lv; bus.load_weight = lw;
    bus.load_bias = lb; bus.valid_in = vi; bus.pxl_in = px;
    @(posedge clk);
    m_fd = 0;
    m_vout = 0;
    if (clr) begin
      m_loaded = 0; m_ld = 0; m_pix = 0; m_err = 0;
    end else if (!m_loaded) begin
      if (vi) m_err = 1;
      if (lv) begin
        m_w[m_ld] = lw; m_b[m_ld] = lb;
        m_ld++;
        if (m_ld == NCH) begin m_loaded = 1; m_ld = 0; end
      end
    end else begin
      if (lv) m_err = 1;
      if (vi) begin
        m_vout = 1;
        m_pxl = px;
        m_wo = m_w[m_pix / PPC];
        m_bo = m_b[m_pix / PPC];
        m_fd = (m_pix == FR - 1);
        m_pix = (m_pix + 1) % FR;
      end
    end
    #1;
    check_all();
    if (bus.frame_done === 1'b1) fd_count++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    bus.param_clr = 0; bus.load_valid = 0; bus.load_weight = '0;
    bus.load_bias = '0; bus.valid_in = 0; bus.pxl_in = '0;
    model_reset();

    phase = "reset";
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all();

    phase = "load1";
    cyc(0, 1, 32'h3F800000, 32'h3F000000, 0, '0);
    cyc(0, 1, 32'h40000000, 32'h3F000000, 0, '0);
    cyc(0, 1, 32'h40400000, 32'h3F000000, 0, '0);
    cyc(0, 1, 32'h40800000, 32'h3F000000, 0, '0);
    chk("load_done_after_4th", {31'd0, bus.load_done}, 32'd1);
    idle(1);

    phase = "b2b";
    fd_count = 0;
    for (int i = 0; i < FR; i++) begin
      cyc(0, 0, '0, '0, 1, 32'h3F800000 + i);
      chk("ch_weight", bus.weight_out, 32'h3F800000 + ((i / PPC) == 0 ? 32'h0 : 32'h0)
          + (((i / PPC) == 0) ? 32'h0 : (32'h00800000 << 0) * 0) + ((i / PPC) == 0 ? 0 :
          ((i / PPC) == 1 ? 32'h00800000 : ((i / PPC) == 2 ? 32'h00C00000 : 32'h01000000))));
    end
    chk("b2b_frame_done_count", fd_count, 1);
    idle(2);

    phase = "gapped";
    fd_count = 0;
    for (int i = 0; i < FR; i++) begin
      cyc(0, 0, '0, '0, 1, 32'h3F800000 + i);
      cyc(0, 0, '0, '0, 0, '0);
    end
    chk("gap_frame_done_count", fd_count, 1);

    phase = "err_run";
    cyc(0, 1, 32'hDEADBEEF, 32'hCAFEF00D, 0, '0);
    for (int i = 0; i < FR; i++) cyc(0, 0, '0, '0, 1, $urandom);

    phase = "err_load";
    cyc(1, 0, '0, '0, 0, '0);
    cyc(0, 0, '0, '0, 1, 32'h12345678);
    idle(2);
    cyc(0, 1, 32'h40A00000, 32'h3E800000, 0, '0);
    cyc(0, 1, 32'h40C00000, 32'h3E800000, 0, '0);
    cyc(0, 1, 32'h40E00000, 32'h3E800000, 0, '0);
    cyc(0, 1, 32'h41000000, 32'h3E800000, 1, 32'h55555555);
    cyc(0, 1, 32'hBAD0BAD0, 32'hBAD0BAD0, 0, '0);
    for (int i = 0; i < FR; i++) cyc(0, 0, '0, '0, 1, $urandom);

    phase = "clr_mid";
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, '0, 1, $urandom);
    cyc(1, 0, '0, '0, 1, 32'h77777777);
    chk("clr_load_done", {31'd0, bus.load_done}, 32'd0);
    chk("clr_valid_out", {31'd0, bus.valid_out}, 32'd0);
    for (int i = 0; i < NCH; i++) cyc(0, 1, 32'h40A00000 + i, 32'h3F000000 + i, 0, '0);
    cyc(0, 0, '0, '0, 1, 32'h3F800000);
    chk("reload_ch0_weight", bus.weight_out, 32'h40A00000);

    phase = "async_rst";
    cyc(0, 0, '0, '0, 1, 32'hABCDEF01);
    chk("pre_rst_valid", {31'd0, bus.valid_out}, 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 1'b1;
    check_all();

    phase = "random";
    for (int n = 0; n < 500; n++) begin
      bit clr, lv, vi;
      clr = ($urandom_range(0, 59) == 0);
      if (m_loaded) begin
        lv = ($urandom_range(0, 29) == 0);
        vi = ($urandom_range(0, 3) != 0);
      end else begin
        lv = ($urandom_range(0, 1) == 1);
        vi = ($urandom_range(0, 9) == 0);
      end
      cyc(clr, lv, $urandom, $urandom, vi, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnn_bn_param_feeder.md
# cnn_bn_param_feeder

Per-channel parameter sequencer that sits directly upstream of the batch-normalization stage. It stores one FP32 weight (scale) and one FP32 bias (shift) per channel. It then streams them alongside the incoming pixel stream, which is channel-major, so the batch-normalization stage sees every pixel with its own channel's parameters on the same cycle. The block has no backpressure: it follows `valid_in` gaps exactly.

## Interface
Parameters:
- `DATA_WIDTH`, 32: pixel/parameter word width (IEEE-754 single).
- `NUM_CHANNEL`, 64: number of channels (parameter entries) per frame; ≥ 1.
- `PXL_PER_CHANNEL`, 1024: pixels per channel plane; ≥ 1.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces reset state immediately.
- `param_clr` in 1: synchronous clear. Returns the block to LOAD and zeroes all counters and the error flag.
- `load_valid` in 1: parameter write strobe.
- `load_weight` in DATA_WIDTH: weight for the next channel entry.
- `load_bias` in DATA_WIDTH: bias for the next channel entry.
- `load_done` out 1: all NUM_CHANNEL entries loaded (state RUN).
- `valid_in` in 1: pixel strobe.
- `pxl_in` in DATA_WIDTH: pixel value.
- `valid_out` out 1: pixel output valid.
- `pxl_out` out DATA_WIDTH: registered pixel.
- `valid_weight_out` out 1: weight valid; always equal to `valid_out`.
- `weight_out` out DATA_WIDTH: weight of the current pixel's channel.
- `valid_bias_out` out 1: bias valid; always equal to `valid_out`.
- `bias_out` out DATA_WIDTH: bias of the current pixel's channel.
- `frame_done` out 1: one-cycle pulse coincident with the last pixel of the last channel on the outputs.
- `err` out 1: sticky protocol-error flag.

## Operation
- Storage: two NUM_CHANNEL-deep register arrays, one for weight and one for bias. Contents are not cleared by reset.
- State LOAD, the reset state:
  - Each `load_valid` writes `load_weight` and `load_bias` to entry `ld_cnt`, then increments `ld_cnt`.
  - On the write with `ld_cnt` = NUM_CHANNEL-1, the block goes to RUN on the next cycle and `ld_cnt` returns to 0.
  - A `valid_in` in LOAD is dropped (no output) and sets `err`. This includes the cycle of the final load beat.
- State RUN:
  - `load_valid` is ignored and sets `err`.
  - Each `valid_in` is accepted. It is output one cycle later with `weight_out`/`bias_out` taken from entry `ch_cnt`.
  - `px_cnt` increments per accepted pixel. At PXL_PER_CHANNEL-1 it wraps to 0 and `ch_cnt` increments.
  - At `ch_cnt` = NUM_CHANNEL-1 with `px_cnt` wrapping, `ch_cnt` wraps to 0. That pixel's output cycle carries `frame_done`=1.
  - The next frame proceeds immediately with the same parameters.
- `param_clr` has priority over all other inputs. In its cycle the block:
  - goes to LOAD;
  - sets `ld_cnt`, `px_cnt` and `ch_cnt` to 0 and `err` to 0;
  - drops any `valid_in` or `load_valid` presented in the same cycle.

  Output registers still complete the one beat already in flight.
- `err` stays high once set, until `reset` or `param_clr`.
- No arithmetic is performed: data passes through bit-exact.

## Timing
- Reset values:
  - All outputs are 0: `valid_out`, `valid_weight_out`, `valid_bias_out`, `pxl_out`, `weight_out`, `bias_out`, `frame_done`, `load_done`, `err`.
  - State is LOAD and all counters are 0.
- Latency: `valid_in` at cycle N produces `valid_out` at cycle N+1. All three valid outputs are identical. Data outputs hold their last value when valid is low.
- Throughput: one pixel per cycle. Back-to-back and gapped `valid_in` are both supported, and gaps do not advance counters.
- `load_done` rises one cycle after the final load beat, and falls one cycle after `param_clr`.
- Reset asserted mid-frame: outputs clear asynchronously. After release the block requires a full reload.

## Test plan
For the bench, override parameters to NUM_CHANNEL=4 and PXL_PER_CHANNEL=3.

1. Reset, then load entries w={1.0,2.0,3.0,4.0} and b={0.5,…}. Expected: `load_done`=1 one cycle after the 4th beat, `err`=0.
2. 12 back-to-back pixels 0x3F800000+i. Expected:
   - `valid_out` for cycles 1–12;
   - `weight_out` = 1.0 ×3, 2.0 ×3, 3.0 ×3, 4.0 ×3;
   - `frame_done` only on output 12.
3. The same 12 pixels with `valid_in` toggling every other cycle. Expected: identical output sequence, with `valid_out` gaps mirroring the input and `frame_done` on the 12th valid beat.
4. Pixel sent during LOAD, and a `load_valid` sent during RUN. Expected: no `valid_out` for the LOAD pixel, `err`=1 that stays set, and parameter contents unchanged.
5. `param_clr` on pixel 5 of a frame. Expected: pixel 5 dropped, `load_done`=0 next cycle, `err`=0. After reloading with w={5.0,…}, the next pixel gets weight 5.0 (channel 0).
6. `reset` low while `valid_out`=1. Expected: all outputs 0 the same cycle, before any clock edge.
